// File: rtl/sfr_bank.sv
// Parametrised SFR bank: RW, W1C sticky and RO status bits, one-edge registered ack.
// No backpressure: one request per enabled cycle; hardware set/update inputs act on every enabled edge.
module sfr_bank #(
  parameter int SFR_WIDTH  = 32,
  parameter int SFR_NUM    = 8,
  parameter int ADDR_WIDTH = $clog2(SFR_NUM),
  parameter logic [SFR_NUM*SFR_WIDTH-1:0] RST_VAL  = '0,
  parameter logic [SFR_NUM*SFR_WIDTH-1:0] WR_MASK  = '1,
  parameter logic [SFR_NUM*SFR_WIDTH-1:0] W1C_MASK = '0
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             sys_clk_en,
  input  logic                             sfr_req,
  input  logic                             sfr_wen,
  input  logic [ADDR_WIDTH-1:0]            sfr_addr,
  input  logic [SFR_WIDTH/8-1:0]           sfr_be,
  input  logic [SFR_WIDTH-1:0]             sfr_din,
  output logic [SFR_WIDTH-1:0]             sfr_dout,
  output logic                             sfr_ack,
  output logic                             sfr_err,
  input  logic [SFR_NUM*SFR_WIDTH-1:0]     hw_set,
  input  logic [SFR_NUM-1:0]               hw_upd_en,
  input  logic [SFR_NUM*SFR_WIDTH-1:0]     hw_upd_din,
  output logic [SFR_NUM*SFR_WIDTH-1:0]     sfr_q
);

  localparam int NB    = SFR_WIDTH / 8;
  localparam int TOTAL = SFR_NUM * SFR_WIDTH;
  localparam logic [TOTAL-1:0] RO_MASK = ~(WR_MASK | W1C_MASK);

  if ((WR_MASK & W1C_MASK) != '0) begin : g_mask_overlap
    $error("sfr_bank: WR_MASK and W1C_MASK overlap");
  end
  if ((SFR_WIDTH % 8) != 0 || SFR_WIDTH < 8) begin : g_bad_width
    $error("sfr_bank: SFR_WIDTH must be a non-zero multiple of 8");
  end
  if (SFR_NUM < 2 || SFR_NUM > 64) begin : g_bad_num
    $error("sfr_bank: SFR_NUM must be in 2..64");
  end

  logic [TOTAL-1:0]     regs_q, regs_d;
  logic [SFR_WIDTH-1:0] dout_q, dout_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic [31:0]          addr_ext;
  logic                 addr_ok;
  logic                 sw_wr;
  logic                 sw_rd;
  logic [SFR_WIDTH-1:0] be_bits;
  logic [SFR_WIDTH-1:0] rd_sel;
  logic [SFR_WIDTH-1:0] cur;
  logic [SFR_WIDTH-1:0] wmask;
  logic [SFR_WIDTH-1:0] clr;
  logic [SFR_WIDTH-1:0] nxt;

  always_comb begin
    addr_ext = 32'(sfr_addr);
    addr_ok  = addr_ext < 32'(SFR_NUM);
    sw_wr    = sfr_req && sfr_wen && addr_ok;
    sw_rd    = sfr_req && !sfr_wen && addr_ok;
    be_bits  = '0;
    for (int k = 0; k < NB; k++) begin
      be_bits[k*8 +: 8] = {8{sfr_be[k]}};
    end
  end

  // Per-register next state; the read mux uses the pre-update value.
  always_comb begin
    regs_d = regs_q;
    rd_sel = '0;
    cur    = '0;
    wmask  = '0;
    clr    = '0;
    nxt    = '0;
    for (int i = 0; i < SFR_NUM; i++) begin
      cur   = regs_q[i*SFR_WIDTH +: SFR_WIDTH];
      wmask = (sw_wr && addr_ext == 32'(i)) ? be_bits : '0;
      clr   = wmask & sfr_din;
      nxt   = (WR_MASK[i*SFR_WIDTH +: SFR_WIDTH] & ((wmask & sfr_din) | (~wmask & cur)))
            | (W1C_MASK[i*SFR_WIDTH +: SFR_WIDTH] & ((cur & ~clr) | hw_set[i*SFR_WIDTH +: SFR_WIDTH]))
            | (RO_MASK[i*SFR_WIDTH +: SFR_WIDTH]
               & (hw_upd_en[i] ? hw_upd_din[i*SFR_WIDTH +: SFR_WIDTH] : cur));
      regs_d[i*SFR_WIDTH +: SFR_WIDTH] = nxt;
      if (addr_ext == 32'(i)) begin
        rd_sel = cur;
      end
    end
  end

  always_comb begin
    ack_d  = sfr_req;
    err_d  = sfr_req && !addr_ok;
    dout_d = sw_rd ? rd_sel : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      regs_q <= RST_VAL;
      dout_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (sys_clk_en) begin
      regs_q <= regs_d;
      dout_q <= dout_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  assign sfr_dout = dout_q;
  assign sfr_ack  = ack_q;
  assign sfr_err  = err_q;
  assign sfr_q    = regs_q;

endmodule

// File: tb/tb_sfr_bank.sv
// Bench for sfr_bank: directed vector table plus randomized traffic against a per-bit reference model.
module tb_sfr_bank;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam logic [N*W-1:0] RST  = {32'h0, 32'h0000_00A5, 32'h0, 32'h0};
  localparam logic [N*W-1:0] WRM  = {32'h0, 32'hFF00_FFFF, 32'hFFFF_FF00, 32'hFFFF_FFFF};
  localparam logic [N*W-1:0] W1CM = {32'h0, 32'h00FF_0000, 32'h0000_00FF, 32'h0};

  logic           sys_clk = 1'b0;
  logic           sys_rst_n, sys_clk_en, sfr_req, sfr_wen;
  logic [AW-1:0]  sfr_addr;
  logic [W/8-1:0] sfr_be;
  logic [W-1:0]   sfr_din, sfr_dout;
  logic           sfr_ack, sfr_err;
  logic [N*W-1:0] hw_set, hw_upd_din, sfr_q;
  logic [N-1:0]   hw_upd_en;

  int n_tests = 0;
  int n_fail  = 0;

  sfr_bank #(
    .SFR_WIDTH(W), .SFR_NUM(N), .ADDR_WIDTH(AW),
    .RST_VAL(RST), .WR_MASK(WRM), .W1C_MASK(W1CM)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_clk_en(sys_clk_en),
    .sfr_req(sfr_req), .sfr_wen(sfr_wen), .sfr_addr(sfr_addr), .sfr_be(sfr_be),
    .sfr_din(sfr_din), .sfr_dout(sfr_dout), .sfr_ack(sfr_ack), .sfr_err(sfr_err),
    .hw_set(hw_set), .hw_upd_en(hw_upd_en), .hw_upd_din(hw_upd_din), .sfr_q(sfr_q)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic           rst_n, en, req, wen;
    logic [AW-1:0]  addr;
    logic [3:0]     be;
    logic [31:0]    din;
    logic [N*W-1:0] hs;
    logic [N-1:0]   ue;
    logic [N*W-1:0] ud;
    logic           e_ack, e_err;
    logic [31:0]    e_dout;
    int             q_idx;
    logic [31:0]    e_q;
  } vec_t;

  vec_t vecs[$];

  // Reference model: register contents as an array, updated bit by bit by access type.
  logic [31:0] m_reg [N];
  logic        m_ack, m_err;
  logic [31:0] m_dout;

  function automatic vec_t mkv(input logic r, input logic e, input logic q, input logic wr,
                               input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d,
                               input logic [N*W-1:0] hs, input logic [N-1:0] ue,
                               input logic [N*W-1:0] ud, input logic ea, input logic ee,
                               input logic [31:0] ed, input int qi, input logic [31:0] eq);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = q; v.wen = wr; v.addr = a; v.be = b; v.din = d;
    v.hs = hs; v.ue = ue; v.ud = ud; v.e_ack = ea; v.e_err = ee; v.e_dout = ed;
    v.q_idx = qi; v.e_q = eq;
    return v;
  endfunction

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] old [N];
    int a;
    for (int r = 0; r < N; r++) old[r] = m_reg[r];
    a = int'(sfr_addr);
    if (!sys_rst_n) begin
      for (int r = 0; r < N; r++) m_reg[r] = RST[r*W +: W];
      m_ack = 0; m_err = 0; m_dout = 0;
    end else if (sys_clk_en) begin
      m_ack  = sfr_req;
      m_err  = sfr_req && a >= N;
      m_dout = (sfr_req && !sfr_wen && a < N) ? old[a] : 32'h0;
      for (int r = 0; r < N; r++) begin
        for (int b = 0; b < W; b++) begin
          bit wr_here;
          wr_here = sfr_req && sfr_wen && a == r && sfr_be[b/8];
          if (WRM[r*W+b]) begin
            if (wr_here) m_reg[r][b] = sfr_din[b];
          end else if (W1CM[r*W+b]) begin
            if (hw_set[r*W+b]) m_reg[r][b] = 1'b1;
            else if (wr_here && sfr_din[b]) m_reg[r][b] = 1'b0;
          end else if (hw_upd_en[r]) begin
            m_reg[r][b] = hw_upd_din[r*W+b];
          end
        end
      end
    end
  endtask

  task automatic drive(input vec_t v);
    sys_rst_n = v.rst_n; sys_clk_en = v.en; sfr_req = v.req; sfr_wen = v.wen;
    sfr_addr = v.addr; sfr_be = v.be; sfr_din = v.din;
    hw_set = v.hs; hw_upd_en = v.ue; hw_upd_din = v.ud;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  initial begin
    localparam logic [N*W-1:0] Z = '0;
    vec_t v;
    // rst en req wen addr be din hw_set upd_en upd_din | ack err dout | q_idx q
    vecs.push_back(mkv(0,0,0,0,0,4'h0,32'h0,Z,4'h0,Z, 0,0,32'h0, 2,32'h0000_00A5));
    vecs.push_back(mkv(1,1,1,0,2,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h0000_00A5, -1,32'h0));
    vecs.push_back(mkv(1,1,0,0,0,4'h0,32'h0,Z,4'h0,Z, 0,0,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,1,1,1,0,4'h5,32'hDEAD_BEEF,Z,4'h0,Z, 1,0,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,1,1,0,0,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h00AD_00EF, 0,32'h00AD_00EF));
    vecs.push_back(mkv(1,1,0,0,0,4'h0,32'h0,{64'h0,32'h0F,32'h0},4'h0,Z, 0,0,32'h0, 1,32'h0F));
    vecs.push_back(mkv(1,1,1,0,1,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h0F, -1,32'h0));
    vecs.push_back(mkv(1,1,1,1,1,4'hF,32'h05,Z,4'h0,Z, 1,0,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,1,1,0,1,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h0A, -1,32'h0));
    vecs.push_back(mkv(1,1,1,1,1,4'hF,32'h0A,{64'h0,32'h02,32'h0},4'h0,Z, 1,0,32'h0, 1,32'h02));
    vecs.push_back(mkv(1,1,1,0,1,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h02, -1,32'h0));
    vecs.push_back(mkv(1,1,0,0,0,4'h0,32'h0,Z,4'h8,{32'h1234_5678,96'h0}, 0,0,32'h0, 3,32'h1234_5678));
    vecs.push_back(mkv(1,1,1,1,3,4'hF,32'hFFFF_FFFF,Z,4'h0,Z, 1,0,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,1,1,0,3,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h1234_5678, -1,32'h0));
    vecs.push_back(mkv(1,1,1,0,5,4'h0,32'h0,Z,4'h0,Z, 1,1,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,1,0,0,0,4'h0,32'h0,Z,4'h0,Z, 0,0,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,0,1,1,0,4'hF,32'hFFFF_FFFF,{64'h0,32'hFF,32'h0},4'hF,'1, 0,0,32'h0, 0,32'h00AD_00EF));
    vecs.push_back(mkv(1,0,1,1,0,4'hF,32'hFFFF_FFFF,{64'h0,32'hFF,32'h0},4'hF,'1, 0,0,32'h0, 1,32'h02));
    vecs.push_back(mkv(1,0,1,1,0,4'hF,32'hFFFF_FFFF,{64'h0,32'hFF,32'h0},4'hF,'1, 0,0,32'h0, 3,32'h1234_5678));
    vecs.push_back(mkv(1,1,1,0,0,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h00AD_00EF, -1,32'h0));
    vecs.push_back(mkv(1,1,1,0,5,4'h0,32'h0,Z,4'h0,Z, 1,1,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,0,0,0,0,4'h0,32'h0,Z,4'h0,Z, 1,1,32'h0, -1,32'h0));
    vecs.push_back(mkv(1,1,1,0,2,4'h0,32'h0,Z,4'h0,Z, 1,0,32'h0000_00A5, -1,32'h0));
    vecs.push_back(mkv(0,1,1,1,0,4'hF,32'hFFFF_FFFF,Z,4'h0,Z, 0,0,32'h0, 0,32'h0));
    vecs.push_back(mkv(1,1,0,0,0,4'h0,32'h0,Z,4'h0,Z, 0,0,32'h0, 2,32'h0000_00A5));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d ack/err/dout", i), {94'h0, sfr_ack, sfr_err, sfr_dout},
            {94'h0, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_dout});
      if (vecs[i].q_idx >= 0)
        check($sformatf("vec%0d sfr_q[%0d]", i, vecs[i].q_idx),
              {96'h0, sfr_q[vecs[i].q_idx*W +: W]}, {96'h0, vecs[i].e_q});
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      v.rst_n = ($urandom_range(0, 39) != 0);
      v.en    = ($urandom_range(0, 3) != 0);
      v.req   = $urandom_range(0, 1) == 1;
      v.wen   = $urandom_range(0, 1) == 1;
      v.addr  = AW'($urandom_range(0, 5));
      v.be    = 4'($urandom);
      v.din   = $urandom;
      for (int r = 0; r < N; r++) begin
        v.hs[r*W +: W] = $urandom & $urandom & $urandom;
        v.ud[r*W +: W] = $urandom;
      end
      v.ue = 4'($urandom);
      drive(v);
      tick();
      check($sformatf("rnd%0d ack/err/dout", c), {94'h0, sfr_ack, sfr_err, sfr_dout},
            {94'h0, m_ack, m_err, m_dout});
      check($sformatf("rnd%0d sfr_q", c), sfr_q, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
